byte_queue: RTL and testbench

BYTE_QUEUE -- requirements
Module: byte_queue

---
 rtl/byte_queue_pkg.sv | 5 +
 rtl/byte_queue_mem.sv | 17 +
 rtl/byte_queue.sv | 85 ++++++++
 tb/tb_byte_queue.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/byte_queue_pkg.sv
// byte_queue_pkg: enqueue handshake state type and default queue depth for byte_queue.
package byte_queue_pkg;
    localparam int DEFAULT_DEPTH = 8;
    typedef enum logic [1:0] {IDLE, ACK, WAIT_LOW} enq_state_t;
endpackage

// File: rtl/byte_queue_mem.sv
// byte_queue_mem: DEPTH x 8 register array with one synchronous write port and one asynchronous read port.
module byte_queue_mem #(
    parameter int DEPTH = 8
) (
    input  logic                     clock_100k,
    input  logic                     write,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [7:0]               wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [7:0]               rd_data
);
    logic [7:0] cells [DEPTH];
    always_ff @(posedge clock_100k) begin
        if (write) cells[wr_addr] <= wr_data;
    end
    assign rd_data = cells[rd_addr];
endmodule

// File: rtl/byte_queue.sv
// byte_queue: circular byte FIFO fed by a level-held valid/one-cycle-ack handshake, popped by dequeue_in.
// Defining BYTE_QUEUE_FLAGS_EN adds empty_out, full_out and a sticky underflow_out.
module byte_queue import byte_queue_pkg::*; #(
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                     clock_100k,
    input  logic                     reset,
    input  logic [7:0]               data_in,
    input  logic                     enqueue_in,
    output logic                     ack_out,
    input  logic                     dequeue_in,
    output logic [7:0]               data_out,
`ifdef BYTE_QUEUE_FLAGS_EN
    output logic [$clog2(DEPTH):0]   len_out,
    output logic                     empty_out,
    output logic                     full_out,
    output logic                     underflow_out
`else
    output logic [$clog2(DEPTH):0]   len_out
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LEN = (AW + 1)'(DEPTH);

    enq_state_t    state, next_state;
    logic [AW-1:0] head, tail;
    logic [7:0]    rd_data;
    logic          write, pop, full, empty;

    assign full  = len_out == FULL_LEN;
    assign empty = len_out == '0;

    always_ff @(posedge clock_100k) begin
        if (reset) state <= IDLE;
        else state <= next_state;
    end

    always_comb begin
        next_state = (state == IDLE) ? ((enqueue_in && !full) ? ACK : IDLE) :
                     (state == ACK)  ? WAIT_LOW :
                     (enqueue_in ? WAIT_LOW : IDLE);
    end

    // full is judged on the registered length, so a pop while full defers the write one cycle
    always_comb begin
        write   = (state == IDLE) && enqueue_in && !full;
        ack_out = state == ACK;
        pop     = dequeue_in && !empty;
    end

    always_ff @(posedge clock_100k) begin
        if (reset) begin
            head     <= '0;
            tail     <= '0;
            len_out  <= '0;
            data_out <= 8'h00;
        end else begin
            if (write) tail <= tail + AW'(1);
            if (pop) begin
                head     <= head + AW'(1);
                data_out <= rd_data;
            end
            len_out <= len_out + {{AW{1'b0}}, write} - {{AW{1'b0}}, pop};
        end
    end

    byte_queue_mem #(.DEPTH(DEPTH)) mem (
        .clock_100k(clock_100k),
        .write(write),
        .wr_addr(tail),
        .wr_data(data_in),
        .rd_addr(head),
        .rd_data(rd_data)
    );

`ifdef BYTE_QUEUE_FLAGS_EN
    assign empty_out = empty;
    assign full_out  = full;
    always_ff @(posedge clock_100k) begin
        if (reset) underflow_out <= 1'b0;
        else if (dequeue_in && empty) underflow_out <= 1'b1;
    end
`else
`endif
endmodule

// File: tb/tb_byte_queue.sv
// tb_byte_queue: directed scoreboard bench for byte_queue (DEPTH=8), flag checks under BYTE_QUEUE_FLAGS_EN.
module tb_byte_queue;
    logic       clock_100k = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] data_in = 8'h00;
    logic       enqueue_in = 1'b0;
    logic       dequeue_in = 1'b0;
    logic       ack_out;
    logic [7:0] data_out;
    logic [3:0] len_out;
`ifdef BYTE_QUEUE_FLAGS_EN
    logic       empty_out, full_out, underflow_out;
`endif

    int         total = 0;
    int         bad = 0;
    logic [7:0] sb [$];
    logic [7:0] last = 8'h00;
    int         acks;

    byte_queue #(.DEPTH(8)) dut (
        .clock_100k(clock_100k),
        .reset(reset),
        .data_in(data_in),
        .enqueue_in(enqueue_in),
        .ack_out(ack_out),
        .dequeue_in(dequeue_in),
        .data_out(data_out),
`ifdef BYTE_QUEUE_FLAGS_EN
        .len_out(len_out),
        .empty_out(empty_out),
        .full_out(full_out),
        .underflow_out(underflow_out)
`else
        .len_out(len_out)
`endif
    );

    always #5 clock_100k = ~clock_100k;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock_100k);
        #1;
    endtask

    task automatic enq(input logic [7:0] b);
        int n = 0;
        data_in = b;
        enqueue_in = 1'b1;
        tick();
        while (!ack_out && n < 20) begin
            tick();
            n++;
        end
        chk("enq_ack", 32'(ack_out), 1);
        if (ack_out) sb.push_back(b);
        enqueue_in = 1'b0;
        tick();
        chk("enq_single_pulse", 32'(ack_out), 0);
        tick();
    endtask

    task automatic pop_chk(input string tag);
        logic [7:0] e;
        e = (sb.size() > 0) ? sb.pop_front() : last;
        dequeue_in = 1'b1;
        tick();
        dequeue_in = 1'b0;
        chk(tag, 32'(data_out), 32'(e));
        chk({tag, "_len"}, 32'(len_out), 32'(sb.size()));
        last = e;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tick();
        tick();
        chk("rst_len", 32'(len_out), 0);
        chk("rst_ack", 32'(ack_out), 0);
        chk("rst_data", 32'(data_out), 0);
`ifdef BYTE_QUEUE_FLAGS_EN
        chk("rst_empty", 32'(empty_out), 1);
        chk("rst_full", 32'(full_out), 0);
        chk("rst_underflow", 32'(underflow_out), 0);
`endif
        reset = 1'b0;

        data_in = 8'hA5;
        enqueue_in = 1'b1;
        tick();
        chk("a5_ack_latency", 32'(ack_out), 1);
        chk("a5_len_latency", 32'(len_out), 1);
        acks = int'(ack_out);
        repeat (3) begin
            tick();
            acks += int'(ack_out);
        end
        chk("a5_one_ack", 32'(acks), 1);
        chk("a5_len_held", 32'(len_out), 1);
        sb.push_back(8'hA5);
        enqueue_in = 1'b0;
        tick();
        tick();
        pop_chk("a5_pop");

        for (int i = 1; i <= 8; i++) enq(8'(i));
        chk("full_len", 32'(len_out), 8);
`ifdef BYTE_QUEUE_FLAGS_EN
        chk("full_flag", 32'(full_out), 1);
`endif
        data_in = 8'h09;
        enqueue_in = 1'b1;
        acks = 0;
        repeat (3) begin
            tick();
            acks += int'(ack_out);
        end
        chk("full_no_ack", 32'(acks), 0);
        chk("full_len_held", 32'(len_out), 8);
        dequeue_in = 1'b1;
        tick();
        dequeue_in = 1'b0;
        last = sb.pop_front();
        chk("full_pop_data", 32'(data_out), 32'(last));
        chk("full_pop_len", 32'(len_out), 7);
        chk("full_pop_no_ack", 32'(ack_out), 0);
        tick();
        chk("deferred_ack", 32'(ack_out), 1);
        chk("deferred_len", 32'(len_out), 8);
        sb.push_back(8'h09);
        enqueue_in = 1'b0;
        tick();
        tick();
        repeat (8) pop_chk("drain");

        pop_chk("empty_pop");
`ifdef BYTE_QUEUE_FLAGS_EN
        chk("underflow_set", 32'(underflow_out), 1);
        repeat (3) tick();
        chk("underflow_sticky", 32'(underflow_out), 1);
`endif

        data_in = 8'h40;
        enqueue_in = 1'b1;
        dequeue_in = 1'b1;
        tick();
        dequeue_in = 1'b0;
        chk("empty_wr_pop_data", 32'(data_out), 32'(last));
        chk("empty_wr_pop_len", 32'(len_out), 1);
        chk("empty_wr_pop_ack", 32'(ack_out), 1);
        sb.push_back(8'h40);
        enqueue_in = 1'b0;
        tick();
        tick();
        pop_chk("pop_40");

        for (int i = 0; i < 20; i++) begin
            enq(8'h10 + 8'(i));
            if (i % 2 == 1) begin
                pop_chk("wrap");
                pop_chk("wrap");
            end
        end

        enq(8'h30);
        enq(8'h31);
        enq(8'h32);
        chk("len3", 32'(len_out), 3);
        data_in = 8'h33;
        enqueue_in = 1'b1;
        dequeue_in = 1'b1;
        tick();
        dequeue_in = 1'b0;
        last = sb.pop_front();
        chk("same_cycle_data", 32'(data_out), 32'(last));
        chk("same_cycle_len", 32'(len_out), 3);
        chk("same_cycle_ack", 32'(ack_out), 1);
        sb.push_back(8'h33);
        enqueue_in = 1'b0;
        tick();
        tick();
        repeat (3) pop_chk("same_cycle_drain");

        data_in = 8'h55;
        enqueue_in = 1'b1;
        tick();
        chk("hs_ack", 32'(ack_out), 1);
        tick();
        chk("hs_wait_low", 32'(ack_out), 0);
        reset = 1'b1;
        tick();
        chk("midrst_len", 32'(len_out), 0);
        chk("midrst_ack", 32'(ack_out), 0);
        chk("midrst_data", 32'(data_out), 0);
`ifdef BYTE_QUEUE_FLAGS_EN
        chk("midrst_underflow", 32'(underflow_out), 0);
`endif
        sb.delete();
        last = 8'h00;
        reset = 1'b0;
        tick();
        chk("rearm_ack", 32'(ack_out), 1);
        chk("rearm_len", 32'(len_out), 1);
        acks = 0;
        repeat (3) begin
            tick();
            acks += int'(ack_out);
        end
        chk("rearm_no_extra_ack", 32'(acks), 0);
        sb.push_back(8'h55);
        enqueue_in = 1'b0;
        tick();
        tick();
        pop_chk("rearm_pop");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
